// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin N:1 multiplexer: the out_sel width
// helper, a generic channel-index type and the pointer reset value.
package mux_pkg;

  // Widest channel index any instance is expected to need.
  localparam int unsigned IDX_W_MAX = 16;

  // Generic channel index, wide enough for any supported N.
  typedef logic [IDX_W_MAX-1:0] chan_idx_t;

  // Round-robin pointer value after reset: search starts at channel 0.
  localparam int unsigned RST_PTR = 0;

  // Width of a channel index for n channels: $clog2(n), never less than 1.
  function automatic int sel_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_rr_n_arbiter.sv
// Combinational round-robin arbiter. The search starts at ptr and wraps
// modulo N. With lock_en set, only lock_idx may win, and it wins only while
// it is requesting.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = sel_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             lock_en,
  input  logic [SEL_W-1:0] lock_idx,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  // Pick the first requester at or after ptr, or the locked channel only.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    if (lock_en) begin
      if (req[lock_idx]) begin
        gnt[lock_idx] = 1'b1;
        gnt_idx       = lock_idx;
        any           = 1'b1;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        idx = (int'(ptr) + i) % N;
        if (!any && req[idx]) begin
          gnt[idx] = 1'b1;
          gnt_idx  = SEL_W'(idx);
          any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mux_rr_n.sv
// N:1 data multiplexer with round-robin arbitration and a registered output
// stage. The handshake on both sides is the usual valid/ready pair: a beat
// moves when valid and ready are both high at a rising edge, and valid never
// depends on ready. in_ready is at most one-hot, it is only raised when the
// output register can load (empty, or being drained this cycle), and it is
// held low while rst_n is low.
// Optional packet locking is built when the PKT_LOCK_EN macro is defined:
// after a non-last beat from channel k, only k may be granted until its
// last beat has been accepted.
module mux_rr_n
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = sel_w(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
`ifdef PKT_LOCK_EN
  input  logic [N-1:0]       in_last,
  output logic               out_last,
`endif
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_sel_q;
  logic [SEL_W-1:0] ptr_q;

  logic             load;
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] gnt_idx;
  logic             any;
  logic [SEL_W-1:0] ptr_next;
  logic [WIDTH-1:0] sel_data;
  logic             lock_en;
  logic [SEL_W-1:0] lock_idx;

`ifdef PKT_LOCK_EN
  logic             lock_q;
  logic [SEL_W-1:0] lock_idx_q;
  logic             out_last_q;

  assign lock_en  = lock_q;
  assign lock_idx = lock_idx_q;
  assign out_last = out_last_q;
`else
  assign lock_en  = 1'b0;
  assign lock_idx = '0;
`endif

  // The output register loads when it is empty or being drained this cycle.
  assign load = !out_valid_q || out_ready;

  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .req      (in_valid),
    .ptr      (ptr_q),
    .lock_en  (lock_en),
    .lock_idx (lock_idx),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .any      (any)
  );

  // Grant is offered only when the output register can take the beat.
  assign in_ready = (rst_n && load) ? gnt : '0;

  // Pointer moves to the channel after the winner, wrapping at N-1.
  assign ptr_next = (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + SEL_W'(1);

  // One-hot AND-OR select of the granted channel's data.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
    end
  end

  // Output register, round-robin pointer and (optionally) packet lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= SEL_W'(RST_PTR);
`ifdef PKT_LOCK_EN
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      out_last_q  <= 1'b0;
`endif
    end else if (load) begin
      if (any) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sel_data;
        out_sel_q   <= gnt_idx;
`ifdef PKT_LOCK_EN
        out_last_q  <= in_last[gnt_idx];
        if (in_last[gnt_idx]) begin
          lock_q <= 1'b0;
          ptr_q  <= ptr_next;
        end else begin
          lock_q     <= 1'b1;
          lock_idx_q <= gnt_idx;
        end
`else
        ptr_q       <= ptr_next;
`endif
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
